mul_iter16: RTL and testbench
=============================

# mul_iter16

Iterative 16x16 unsigned shift-and-add multiplier for the execute stage. It sits directly upstream of the shared 16-bit carry-in/carry-out adder: each cycle it drives the adder's operand and carry-in ports and consumes its sum and carry-out. It produces a 32-bit product in 16 iteration cycles behind a start/busy/done handshake. The execute stage holds the instruction while `busy` is high.

## Interface
- Parameters: none. Width is fixed at 16 because the shared adder is fixed at 16 bits.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a multiply; sampled only in IDLE or DONE.
- `opA` input 16: multiplicand; captured on an accepted start.
- `opB` input 16: multiplier; captured on an accepted start.
- `busy` output 1: high throughout RUN.
- `done` output 1: single-cycle pulse; the product is valid in that cycle.
- `prodHi` output 16: product bits [31:16]; held until the next accepted start.
- `prodLo` output 16: product bits [15:0]; held until the next accepted start.
- `addA` output 16: to adder A; carries the hi accumulator.
- `addB` output 16: to adder B; carries mcand if lo[0] is 1, else 0x0000.
- `addI` output 1: to adder carry-in; always 0.
- `addS` input 16: adder sum.
- `addO` input 1: adder carry-out.

## Operation
- Registers:
  - `mcand[15:0]`: latched opA.
  - `hi[15:0]`: accumulator.
  - `lo[15:0]`: multiplier shifting out while product bits shift in.
  - `cnt[4:0]`: iteration counter.
  - `state`: IDLE/RUN/DONE.
- Reset: state=IDLE; mcand, hi, lo = 0; cnt=0; busy=0, done=0; prodHi=prodLo=0x0000.
- IDLE:
  - On start=1: mcand<=opA, lo<=opB, hi<=0, cnt<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, once per cycle:
  - hi <= {addO, addS[15:1]}.
  - lo <= {addS[0], lo[15:1]}.
  - cnt <= cnt+1.
- RUN exit: when cnt==15, go to DONE after that update (16 iterations in total).
- Result: after 16 iterations, {hi,lo} = opA*opB exactly. The result never overflows 32 bits, and addO carries bit 16 of each partial sum.
- DONE:
  - done=1 for exactly one cycle.
  - With start=1: accept the new operands exactly as in IDLE and go to RUN. This gives back-to-back operation with no bubble.
  - With start=0: go to IDLE.
- Outputs: prodHi/prodLo are driven directly from hi/lo. They change during RUN and are defined as valid only when done=1 and afterwards in IDLE.
- Start during RUN: ignored. Operands are not recaptured and the count is unaffected.
- Reset mid-RUN: aborts immediately to the reset values. No done pulse is generated.

## Timing
- Start accepted at edge 0.
- Iterations occupy edges 1..16; busy is high during the cycles after edges 0..15.
- done is high in the cycle after edge 16. Latency from accepting start to done is 17 cycles.
- Throughput: one product per 17 cycles.
- Adder path: combinational through the external adder within one cycle. addA and addB are driven from registers, so there is no combinational path from the block's inputs.

## Configuration
- Macro: `MUL_ADDER_GATE_EN`.
- Defined: outside RUN, addA, addB and addI are forced to 0. This quiets the shared adder and lets other users of the adder see a zero contribution.
- Undefined: addA, addB and addI always reflect hi, mcand/lo[0] and 0 regardless of state.
- The product, latency and handshake are identical in both builds.

## Test plan
- Reset, then opA=0x0003, opB=0x0005, pulse start: done after 17 cycles with prodHi=0x0000, prodLo=0x000F; busy high for 16 cycles.
- opA=0xFFFF, opB=0xFFFF: prodHi=0xFFFE, prodLo=0x0001. This exercises addO on every iteration.
- opA=0x1234, opB=0x0000, with start pulsed again at RUN cycle 5 using opA=0x0001, opB=0x0001: the second start is ignored and the result is 0x0000_0000 at cycle 17.
- Back-to-back: start held high; operands are 0x00FF*0x0101 for the first product, then 0x8000*0x0002 accepted on the done cycle. Done pulses at cycles 17 and 34 with products 0x0000FFFF and 0x00010000.
- Assert rst at RUN cycle 8 of 0x7FFF*0x7FFF: immediately busy=0, done=0, prod=0; no done pulse follows. A new multiply then completes correctly.
- With `MUL_ADDER_GATE_EN` defined: addA=addB=0 and addI=0 in IDLE and DONE. Undefined: addA tracks hi in IDLE. The product matches in both builds.

Source files
------------

// File: rtl/mul_iter16.sv
// mul_iter16: iterative 16x16 unsigned shift-and-add multiplier.
// Produces a 32-bit product in 16 iteration cycles behind a start/busy/done
// handshake. Each iteration uses the external shared 16-bit adder: this block
// drives its operands and carry-in, then consumes its sum and carry-out.
// Optional build macro: MUL_ADDER_GATE_EN. When it is defined, the adder
// operands and carry-in are forced to zero outside RUN, so the shared adder
// stays quiet.
module mul_iter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    output logic        busy,
    output logic        done,
    output logic [15:0] prodHi,
    output logic [15:0] prodLo,
    output logic [15:0] addA,
    output logic [15:0] addB,
    output logic        addI,
    input  logic [15:0] addS,
    input  logic        addO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] hi_q, hi_d;
    logic [15:0] lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] add_b_raw;

    // Next-state logic: accept operands in IDLE/DONE, otherwise run one shift-add step.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts a new start just like IDLE, so products can run
                // back to back with no idle cycle in between.
                if (start) begin
                    mcand_d = opA;
                    lo_d    = opB;
                    hi_d    = 16'h0000;
                    cnt_d   = 5'd0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // The adder's carry-out is bit 16 of the partial sum. Shifting it into
                // hi keeps the accumulator exact. The sum's low bit becomes the next
                // product bit, and it shifts into lo as the multiplier bits shift out.
                hi_d  = {addO, addS[15:1]};
                lo_d  = {addS[0], lo_q[15:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Register all state and the handshake outputs. Reset aborts any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= 16'h0000;
            hi_q    <= 16'h0000;
            lo_q    <= 16'h0000;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Select the adder's B operand: add the multiplicand only when the current multiplier bit is set.
    always_comb begin
        add_b_raw = lo_q[0] ? mcand_q : 16'h0000;
    end

`ifdef MUL_ADDER_GATE_EN
    // Drive the adder from registers only while running; outside RUN it sees zero.
    always_comb begin
        addA = 16'h0000;
        addB = 16'h0000;
        addI = 1'b0;
        if (state_q == RUN) begin
            addA = hi_q;
            addB = add_b_raw;
        end
    end
`else
    // Drive the adder from registers at all times. Its result is only consumed in RUN.
    always_comb begin
        addA = hi_q;
        addB = add_b_raw;
        addI = 1'b0;
    end
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign prodHi = hi_q;
    assign prodLo = lo_q;

endmodule

// File: tb/tb_mul_iter16.sv
// tb_mul_iter16: directed testbench for mul_iter16.
// Models the shared 16-bit adder combinationally and checks products, handshake
// timing, start-ignore during RUN, back-to-back operation, reset abort and the
// adder port behaviour outside RUN. This includes the MUL_ADDER_GATE_EN build.
module tb_mul_iter16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        busy;
    logic        done;
    logic [15:0] prodHi;
    logic [15:0] prodLo;
    logic [15:0] addA;
    logic [15:0] addB;
    logic        addI;
    logic [15:0] addS;
    logic        addO;

    int checks;
    int failures;

    mul_iter16 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opA    (opA),
        .opB    (opB),
        .busy   (busy),
        .done   (done),
        .prodHi (prodHi),
        .prodLo (prodLo),
        .addA   (addA),
        .addB   (addB),
        .addI   (addI),
        .addS   (addS),
        .addO   (addO)
    );

    // Shared adder model: a 17-bit sum of both operands plus the carry-in
    assign {addO, addS} = {1'b0, addA} + {1'b0, addB} + {16'h0000, addI};

    // Free-running clock with a 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        opA   = 16'h0000;
        opB   = 16'h0000;
        #12;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_handshake got busy,done=%b%b exp=00", busy, done);
        end
        checks++;
        if ({prodHi, prodLo} !== 32'h0000_0000) begin
            failures++;
            $display("[TB] FAIL reset_product got=%h%h exp=00000000", prodHi, prodLo);
        end
        checks++;
        if ({addA, addB, addI} !== 33'h0) begin
            failures++;
            $display("[TB] FAIL reset_adder got addA=%h addB=%h addI=%b exp=0", addA, addB, addI);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle_busy got=%b exp=0", busy);
        end
    endtask

    // 3 * 5 = 15. The 17-cycle latency counts the accept cycle plus 16 edges.
    task automatic test_basic;
        int edges;
        int busy_cycles;
        opA   = 16'h0003;
        opB   = 16'h0005;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_busy_first got=%b exp=1", busy);
        end
        checks++;
        if (addA !== 16'h0000 || addB !== 16'h0003 || addI !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_adder_first got addA=%h addB=%h addI=%b exp 0000/0003/0", addA, addB, addI);
        end
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            edges++;
        end
        checks++;
        if (edges !== 16) begin
            failures++;
            $display("[TB] FAIL basic_latency got edges=%0d exp=16", edges);
        end
        checks++;
        if (busy_cycles !== 16) begin
            failures++;
            $display("[TB] FAIL basic_busy_cycles got=%0d exp=16", busy_cycles);
        end
        checks++;
        if ({prodHi, prodLo} !== 32'h0000_000F || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_product got=%h%h busy=%b exp=0000000f busy=0", prodHi, prodLo, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {prodHi, prodLo} !== 32'h0000_000F) begin
            failures++;
            $display("[TB] FAIL basic_after_done got done=%b busy=%b prod=%h%h exp 0/0/0000000f", done, busy, prodHi, prodLo);
        end
    endtask

    // 0xFFFF * 0xFFFF = 0xFFFE0001. The carry-out is used on every iteration.
    task automatic test_max;
        int edges;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
`ifdef MUL_ADDER_GATE_EN
        exp_a = 16'h0000;
        exp_b = 16'h0000;
`else
        exp_a = 16'hFFFE;
        exp_b = 16'hFFFF;
`endif
        opA   = 16'hFFFF;
        opB   = 16'hFFFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checks++;
        if (done !== 1'b1 || {prodHi, prodLo} !== 32'hFFFE_0001) begin
            failures++;
            $display("[TB] FAIL max_product got done=%b prod=%h%h exp done=1 prod=fffe0001", done, prodHi, prodLo);
        end
        checks++;
        if (addA !== exp_a || addB !== exp_b || addI !== 1'b0) begin
            failures++;
            $display("[TB] FAIL max_adder_done got addA=%h addB=%h addI=%b exp %h/%h/0", addA, addB, addI, exp_a, exp_b);
        end
        @(posedge clk);
        #1;
        checks++;
        if (addA !== exp_a || addB !== exp_b || addI !== 1'b0 || {prodHi, prodLo} !== 32'hFFFE_0001) begin
            failures++;
            $display("[TB] FAIL max_adder_idle got addA=%h addB=%h addI=%b prod=%h%h exp %h/%h/0 fffe0001",
                     addA, addB, addI, prodHi, prodLo, exp_a, exp_b);
        end
    endtask

    // Second start during RUN cycle 5 must be ignored: 0x1234 * 0 = 0 and timing is unchanged.
    task automatic test_start_ignored;
        int edges;
        opA   = 16'h1234;
        opB   = 16'h0000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 0;
        while (!done && edges < 40) begin
            if (edges == 4) begin
                start = 1'b1;
                opA   = 16'h0001;
                opB   = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        checks++;
        if (edges !== 16) begin
            failures++;
            $display("[TB] FAIL ignore_latency got edges=%0d exp=16", edges);
        end
        checks++;
        if ({prodHi, prodLo} !== 32'h0000_0000) begin
            failures++;
            $display("[TB] FAIL ignore_product got=%h%h exp=00000000", prodHi, prodLo);
        end
        @(posedge clk);
        #1;
    endtask

    // Start held high: 0xFF*0x101=0xFFFF, then 0x8000*2=0x10000 accepted on the done cycle.
    task automatic test_back_to_back;
        int edges;
        opA   = 16'h00FF;
        opB   = 16'h0101;
        start = 1'b1;
        @(posedge clk);
        #1;
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checks++;
        if (edges !== 16 || {prodHi, prodLo} !== 32'h0000_FFFF) begin
            failures++;
            $display("[TB] FAIL b2b_first got edges=%0d prod=%h%h exp 16 0000ffff", edges, prodHi, prodLo);
        end
        opA = 16'h8000;
        opB = 16'h0002;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_no_bubble got busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        checks++;
        if (edges !== 16 || {prodHi, prodLo} !== 32'h0001_0000) begin
            failures++;
            $display("[TB] FAIL b2b_second got edges=%0d prod=%h%h exp 16 00010000", edges, prodHi, prodLo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_to_idle got done=%b busy=%b exp 0/0", done, busy);
        end
    endtask

    // Reset at RUN cycle 8 of 0x7FFF*0x7FFF aborts at once. A new multiply then gives 0x3FFF0001.
    task automatic test_reset_mid_run;
        int   edges;
        logic seen_done;
        opA   = 16'h7FFF;
        opB   = 16'h7FFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || {prodHi, prodLo} !== 32'h0000_0000) begin
            failures++;
            $display("[TB] FAIL abort_state got busy=%b done=%b prod=%h%h exp 0/0/00000000", busy, done, prodHi, prodLo);
        end
        #2 rst = 1'b0;
        seen_done = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_no_done got seen_done=%b busy=%b exp 0/0", seen_done, busy);
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checks++;
        if (edges !== 16 || {prodHi, prodLo} !== 32'h3FFF_0001) begin
            failures++;
            $display("[TB] FAIL abort_recover got edges=%0d prod=%h%h exp 16 3fff0001", edges, prodHi, prodLo);
        end
        @(posedge clk);
        #1;
    endtask

    // Run every scenario in sequence, then report
    initial begin
        checks   = 0;
        failures = 0;
        test_reset;
        test_basic;
        test_max;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
